// File: rtl/reg_read_port.sv
// rtl/reg_read_port.sv - register file read side: operand select, WB bypass, load-use scoreboard, ID/EX register
//
// Purpose:
//   Reads two source operands for the instruction in ID.
//   A writeback in the same cycle is forwarded to the reader.
//   Register 31 always reads as zero.
//   Outstanding load destinations are tracked so that a dependent reader
//   stalls until the load data returns.
//   Accepted operands are captured into the ID/EX pipeline register.
//
// Ports:
//   clk, reset          single clock; synchronous active-high reset
//   q                   current register array contents, one entry per register
//   wb_en/addr/data     writeback happening this cycle
//   id_valid            instruction present in ID
//   ra1, ra2            source register indices
//   id_wr, id_rd        destination write enable / index
//   id_load             destination value comes from memory
//   flush               kill the instruction currently in ID
//   stall               combinational; hold ID and insert a bubble into EX
//   ex_valid, ex_wr     registered EX valid / write flag
//   rd1, rd2, ex_rd     registered operands and destination
module reg_read_port #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] q [(2**ADDR_WIDTH)-1:0],
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  id_valid,
  input  logic [ADDR_WIDTH-1:0] ra1,
  input  logic [ADDR_WIDTH-1:0] ra2,
  input  logic                  id_wr,
  input  logic [ADDR_WIDTH-1:0] id_rd,
  input  logic                  id_load,
  input  logic                  flush,
  output logic                  stall,
  output logic                  ex_valid,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2,
  output logic [ADDR_WIDTH-1:0] ex_rd,
  output logic                  ex_wr
);

  localparam int NREGS = 2**ADDR_WIDTH;
  // Highest index is the architectural zero register.
  localparam logic [ADDR_WIDTH-1:0] ZR = '1;

  // One bit per register.
  // The zero-register bit is never set, so it always reads as 0.
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_nxt;

  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;
  logic hit1;
  logic hit2;
  logic hz1;
  logic hz2;
  logic accept;

  // Bypass match: a writeback to the same non-zero register this cycle.
  assign hit1 = wb_en && (wb_addr == ra1);
  assign hit2 = wb_en && (wb_addr == ra2);

  // Operand select.
  // The zero register wins over both bypass and array contents.
  always_comb begin
    op1 = q[ra1];
    if (ra1 == ZR)
      op1 = '0;
    else if (hit1)
      op1 = wb_data;

    op2 = q[ra2];
    if (ra2 == ZR)
      op2 = '0;
    else if (hit2)
      op2 = wb_data;
  end

  // Hazard occurs when the register is still pending and not returning right now.
  // The returning writeback releases the stall in the same cycle, via the bypass.
  assign hz1 = (ra1 != ZR) && pending[ra1] && !hit1;
  assign hz2 = (ra2 != ZR) && pending[ra2] && !hit2;

  // stall reads only pending and the current inputs.
  // accept consumes stall.
  // pending_nxt feeds only the register, so there is no loop.
  assign stall  = id_valid && !flush && (hz1 || hz2);
  assign accept = id_valid && !stall && !flush;

  // Clear from the writeback first, then set from the new load.
  // When both hit the same register, the later (set) assignment wins.
  // That covers the case of a new load re-targeting a register whose old load returns now.
  always_comb begin
    pending_nxt = pending;
    if (wb_en && (wb_addr != ZR))
      pending_nxt[wb_addr] = 1'b0;
    if (accept && id_wr && id_load && (id_rd != ZR))
      pending_nxt[id_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // ID/EX pipeline register.
  // A bubble clears only the control bits.
  // The data and destination fields hold their last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid <= 1'b0;
      ex_wr    <= 1'b0;
      rd1      <= '0;
      rd2      <= '0;
      ex_rd    <= ZR;
    end else if (accept) begin
      ex_valid <= 1'b1;
      ex_wr    <= id_wr;
      rd1      <= op1;
      rd2      <= op2;
      ex_rd    <= id_rd;
    end else begin
      ex_valid <= 1'b0;
      ex_wr    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_read_port.sv
// tb/tb_reg_read_port.sv - directed self-checking bench for reg_read_port
module tb_reg_read_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] q [31:0];
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic        id_valid;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        id_wr;
  logic [4:0]  id_rd;
  logic        id_load;
  logic        flush;
  logic        stall;
  logic        ex_valid;
  logic [63:0] rd1;
  logic [63:0] rd2;
  logic [4:0]  ex_rd;
  logic        ex_wr;

  int passed = 0;
  int total  = 0;

  reg_read_port #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .q(q),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .id_valid(id_valid), .ra1(ra1), .ra2(ra2),
    .id_wr(id_wr), .id_rd(id_rd), .id_load(id_load), .flush(flush),
    .stall(stall), .ex_valid(ex_valid), .rd1(rd1), .rd2(rd2),
    .ex_rd(ex_rd), .ex_wr(ex_wr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_en = 0; wb_addr = 0; wb_data = 0;
    id_valid = 0; ra1 = 0; ra2 = 0;
    id_wr = 0; id_rd = 0; id_load = 0; flush = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) q[i] = 64'h1000 + 64'(i);
    idle();
    reset = 1;
    step();
    step();
    reset = 0;
    check("rst_ex_valid", 64'(ex_valid), 64'd0);
    check("rst_ex_wr",    64'(ex_wr),    64'd0);
    check("rst_rd1",      rd1,           64'd0);
    check("rst_rd2",      rd2,           64'd0);
    check("rst_ex_rd",    64'(ex_rd),    64'd31);
    check("rst_stall",    64'(stall),    64'd0);

    // Basic read, with X31 forced to zero.
    q[5] = 64'd128;
    id_valid = 1; ra1 = 5; ra2 = 31; id_wr = 1; id_rd = 10;
    step();
    check("rd_rd1",      rd1,           64'd128);
    check("rd_rd2_x31",  rd2,           64'd0);
    check("rd_ex_valid", 64'(ex_valid), 64'd1);
    check("rd_ex_rd",    64'(ex_rd),    64'd10);
    check("rd_ex_wr",    64'(ex_wr),    64'd1);

    // Write-before-read bypass.
    q[3] = 64'd7;
    wb_en = 1; wb_addr = 3; wb_data = 64'd99; ra1 = 3; ra2 = 5;
    step();
    check("byp_rd1", rd1, 64'd99);
    check("byp_rd2", rd2, 64'd128);

    // A writeback to X31 is never bypassed, and X31 still reads zero.
    wb_addr = 31; ra1 = 31; ra2 = 3;
    step();
    check("x31_rd1", rd1, 64'd0);
    check("x31_rd2", rd2, 64'd7);

    // Load to X31 must not create a hazard.
    wb_en = 0; id_load = 1; id_rd = 31; ra1 = 0; ra2 = 0;
    step();
    id_load = 0; id_rd = 12; ra1 = 31; ra2 = 31;
    #1 check("x31_load_nostall", 64'(stall), 64'd0);

    // Load-use: accept load to x4, then a reader of x4.
    id_load = 1; id_wr = 1; id_rd = 4; ra1 = 0; ra2 = 0;
    #1 check("ld_accept_nostall", 64'(stall), 64'd0);
    step();
    check("ld_ex_rd", 64'(ex_rd), 64'd4);
    id_load = 0; id_rd = 11; ra1 = 1; ra2 = 4; q[4] = 64'd200;
    #1 check("lu_stall0", 64'(stall), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("lu_bubble", 64'(ex_valid), 64'd0);
      check("lu_stall",  64'(stall),    64'd1);
    end
    wb_en = 1; wb_addr = 4; wb_data = 64'd55;
    #1 check("lu_release", 64'(stall), 64'd0);
    step();
    check("lu_rd2",      rd2,           64'd55);
    check("lu_rd1",      rd1,           64'h1001);
    check("lu_ex_valid", 64'(ex_valid), 64'd1);
    check("lu_ex_rd",    64'(ex_rd),    64'd11);
    wb_en = 0;
    #1 check("lu_cleared", 64'(stall), 64'd0);

    // Same-cycle clear and set of x6: the set must win.
    id_load = 1; id_rd = 6; ra1 = 0; ra2 = 0;
    step();
    wb_en = 1; wb_addr = 6; wb_data = 64'd1;
    step();
    wb_en = 0; id_load = 0; id_wr = 0; ra1 = 6;
    #1 check("setwin_stall", 64'(stall), 64'd1);
    flush = 1;
    #1 check("flush_masks_stall", 64'(stall), 64'd0);
    step();
    check("flush_bubble", 64'(ex_valid), 64'd0);
    flush = 0; id_valid = 0; wb_en = 1; wb_addr = 6;
    step();
    wb_en = 0;

    // Flushed load to x8 must not enter the scoreboard.
    id_valid = 1; id_wr = 1; id_load = 1; id_rd = 8; flush = 1; ra1 = 0;
    step();
    check("fl_ex_valid", 64'(ex_valid), 64'd0);
    check("fl_ex_wr",    64'(ex_wr),    64'd0);
    flush = 0; id_load = 0; id_rd = 13; ra1 = 8;
    #1 check("fl_nostall", 64'(stall), 64'd0);
    step();
    check("fl_accept", 64'(ex_valid), 64'd1);

    // Reset arriving mid-stall clears the scoreboard.
    id_load = 1; id_rd = 9; ra1 = 0;
    step();
    id_load = 0; id_rd = 14; ra1 = 9;
    #1 check("rs_stall", 64'(stall), 64'd1);
    reset = 1;
    step();
    check("rs_ex_valid", 64'(ex_valid), 64'd0);
    check("rs_ex_rd",    64'(ex_rd),    64'd31);
    check("rs_ex_wr",    64'(ex_wr),    64'd0);
    check("rs_rd1",      rd1,           64'd0);
    reset = 0;
    #1 check("rs_nostall", 64'(stall), 64'd0);
    step();
    check("rs_accept", 64'(ex_valid), 64'd1);
    check("rs_rd1_q9", rd1,           64'h1009);

    // A late writeback to the cleared x9 is harmless.
    wb_en = 1; wb_addr = 9; wb_data = 64'd77; ra1 = 2;
    step();
    check("late_wb_rd1", rd1, 64'h1002);
    wb_en = 0; ra1 = 9;
    #1 check("late_wb_nostall", 64'(stall), 64'd0);

    idle();
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reg_read_port.md
# reg_read_port

Read side of the 64-bit, 32-entry register file in the pipelined ARM CPU. Selects two source operands from the register array outputs, bypasses a same-cycle writeback, forces X31 to zero, and tracks outstanding load destinations in a scoreboard to raise a load-use stall. Operands are registered into the ID/EX pipeline boundary, with stall and flush handling.

## Interface
- DATA_WIDTH, 64, operand width
- ADDR_WIDTH, 5, register index width; NREGS = 2**ADDR_WIDTH = 32
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- q  in  DATA_WIDTH x NREGS (unpacked [NREGS-1:0])  current register array contents
- wb_en  in  1  writeback occurring this cycle
- wb_addr  in  ADDR_WIDTH  writeback destination
- wb_data  in  DATA_WIDTH  writeback value
- id_valid  in  1  decoded instruction present in ID
- ra1, ra2  in  ADDR_WIDTH  source register indices
- id_wr  in  1  instruction writes a register
- id_rd  in  ADDR_WIDTH  destination index
- id_load  in  1  destination value comes from memory (long latency)
- flush  in  1  kill instruction currently in ID
- stall  out  1  combinational; hold ID, insert bubble
- ex_valid  out  1  registered; EX stage holds a valid instruction
- rd1, rd2  out  DATA_WIDTH  registered operands
- ex_rd  out  ADDR_WIDTH  registered destination
- ex_wr  out  1  registered write flag

## Operation
- Operand select per port (combinational, addr = ra1 or ra2):
  - addr == 31 -> 0 (no bypass, no stall, ever)
  - else wb_en && wb_addr == addr -> wb_data (write-before-read bypass)
  - else q[addr]
- Scoreboard pending[30:0]:
  - accept = id_valid && !stall && !flush
  - set pending[id_rd] on accept && id_wr && id_load && id_rd != 31
  - clear pending[wb_addr] on wb_en && wb_addr != 31
  - set and clear of the same bit in the same cycle: set wins
  - wb_addr == 31 or id_rd == 31 never touches the scoreboard
- hz(a) = a != 31 && pending[a] && !(wb_en && wb_addr == a)
- stall = id_valid && !flush && (hz(ra1) || hz(ra2)); a writeback resolving the pending register releases the stall in that same cycle, using the bypassed value
- Pipeline register update each posedge (non-reset):
  - accept: rd1/rd2 <= selected operands; ex_rd <= id_rd; ex_wr <= id_wr; ex_valid <= 1
  - otherwise (stall, flush, or !id_valid): ex_valid <= 0, ex_wr <= 0; rd1, rd2, ex_rd hold
- flush does not clear pending; loads already issued still write back and clear their bits

## Timing
- Reset (sync, priority over all): ex_valid = 0, ex_wr = 0, rd1 = rd2 = 0, ex_rd = 31, pending = 0; stall therefore 0 in the cycle after reset
- Reset mid-operation: scoreboard cleared; later writebacks to cleared bits are harmless
- Operand latency: 1 cycle (ID inputs at edge N -> rd1/rd2 valid after edge N)
- Load-use: load accepted at edge N sets pending after N; dependent instruction in ID after N stalls until the cycle wb_en matches, then accepts at that edge with wb_data
- stall depends only on current inputs and pending; no combinational path from stall back into the pending read

## Test plan
- Reset, then q[5] = 64'd128, ra1 = 5, ra2 = 31, id_valid = 1 -> next cycle rd1 = 128, rd2 = 0, ex_valid = 1
- q[3] = 7, wb_en = 1, wb_addr = 3, wb_data = 99, ra1 = 3 -> rd1 = 99; same with wb_addr = 31, ra1 = 31 -> rd1 = 0
- Accept load id_rd = 4, next cycle ra2 = 4 with no writeback -> stall = 1, ex_valid = 0 for 3 cycles; wb_en to 4 with data 55 -> stall = 0 that cycle, rd2 = 55 next cycle, pending[4] = 0
- Same cycle: wb clears pending[6] while new load to 6 accepted -> pending[6] = 1, following reader of 6 stalls
- flush with load to 8 in ID -> ex_valid = 0, pending[8] stays 0, no stall on later ra1 = 8
- Set pending[9], assert reset mid-stall -> stall = 0, ex_valid = 0, ex_rd = 31, pending = 0 after the edge
